// File: rtl/score_disp_pkg.sv
// Shared definitions for the score/timer display controller: blank code,
// controller states and the saturation-limit helper.
package score_disp_pkg;

  localparam logic [3:0] DIGIT_BLANK = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Largest value representable with n decimal digits (10**n - 1).
  function automatic int calc_max_val(input int n);
    int v;
    v = 1;
    for (int i = 0; i < n; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/score_display_ctrl_adj3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Binary-to-BCD display controller: one double-dabble shift per clock,
// saturation, leading-zero blanking and gated decoder enables.
module score_display_ctrl
  import score_disp_pkg::*;
#(
  parameter int BIN_W   = 10,
  parameter int DIGITS  = 3,
  parameter int MAX_VAL = calc_max_val(DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [BIN_W-1:0]      value,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic                  digit_en,
  output logic [4*DIGITS-1:0]   digits,
  output state_t                state_dbg
);

  // Handshake: load is a one-cycle request sampled on a rising edge; it is
  // never refused. While busy it lands in a one-deep pending slot (last
  // request wins), and done pulses once per result written to digits/ovf.

  localparam int              BCD_W    = 4 * DIGITS;
  localparam int              CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [31:0]     MAX_U    = 32'(MAX_VAL);

  state_t             state;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   digits_nxt;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               blank_q;
  logic               ovf_q;
  logic               lz_run;

  logic               pend_vld;
  logic [BIN_W-1:0]   pend_val;
  logic               pend_blank;

  logic               start_req;
  logic [BIN_W-1:0]   start_val;
  logic               start_blank;
  logic               start_ovf;
  logic [BIN_W-1:0]   start_sat;

  assign state_dbg = state;

  // A fresh load in the UPDATE cycle takes priority over an older pending one.
  always_comb begin
    start_req   = 1'b0;
    start_val   = value;
    start_blank = blank_lz;
    case (state)
      IDLE: begin
        start_req = load;
      end
      UPDATE: begin
        start_req = load | pend_vld;
        if (!load) begin
          start_val   = pend_val;
          start_blank = pend_blank;
        end
      end
      default: begin
        start_req = 1'b0;
      end
    endcase
    start_ovf = (32'(start_val) > MAX_U);
    start_sat = start_ovf ? BIN_W'(MAX_U) : start_val;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Blank zeros from the top digit down until the first non-zero; digit 0 always shows.
  always_comb begin
    digits_nxt = bcd_q;
    lz_run     = blank_q;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lz_run && (bcd_q[4*i +: 4] == 4'd0)) begin
        digits_nxt[4*i +: 4] = DIGIT_BLANK;
      end else begin
        lz_run = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      digit_en   <= 1'b0;
      digits     <= {DIGITS{DIGIT_BLANK}};
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      blank_q    <= 1'b0;
      ovf_q      <= 1'b0;
      pend_vld   <= 1'b0;
      pend_val   <= '0;
      pend_blank <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_req) begin
        bin_q   <= start_sat;
        bcd_q   <= '0;
        cnt_q   <= '0;
        blank_q <= start_blank;
        ovf_q   <= start_ovf;
        busy    <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_req) begin
            state <= CONV;
          end
        end
        CONV: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state <= UPDATE;
          end
          if (load) begin
            pend_vld   <= 1'b1;
            pend_val   <= value;
            pend_blank <= blank_lz;
          end
        end
        UPDATE: begin
          digits   <= digits_nxt;
          ovf      <= ovf_q;
          digit_en <= 1'b1;
          done     <= 1'b1;
          pend_vld <= 1'b0;
          if (start_req) begin
            state <= CONV;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
